// File: rtl/spi_request_arbiter_pkg.sv
// Shared types and defaults for the SPI request arbiter.
package spi_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        LAUNCH = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_TIMEOUT = 64;
    // Watchdog counter width for the default TIMEOUT (2^CW >= TIMEOUT).
    localparam int DEF_CW      = 7;

    // Width of a requester index; never zero, even for tiny N.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_request_arbiter_if.sv
// Requester-side and SPI-master-side signals of the arbiter.
// The slave modport is the arbiter's view; master is the environment's.
interface spi_request_arbiter_if
    import spi_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ckp;
    logic [N_REQ-1:0]   req_cph;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   rsp_valid;
    logic [7:0]         rsp_data;
    logic               rsp_err;
    logic [7:0]         m_data;
    logic               m_ckp;
    logic               m_cph;
    logic               m_start;
    logic               m_abort;
    logic               m_done;
    logic [7:0]         m_rx;

    modport slave (
        input  req, req_data, req_ckp, req_cph, m_done, m_rx,
        output gnt, rsp_valid, rsp_data, rsp_err,
        output m_data, m_ckp, m_cph, m_start, m_abort
    );

    modport master (
        output req, req_data, req_ckp, req_cph, m_done, m_rx,
        input  gnt, rsp_valid, rsp_data, rsp_err,
        input  m_data, m_ckp, m_cph, m_start, m_abort
    );
endinterface

// File: rtl/spi_request_arbiter_picker.sv
// Combinational round-robin pick: first pending request at or above the
// pointer, wrapping modulo N_REQ.
module spi_rr_picker
    import spi_arb_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    localparam int IW    = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_onehot,
    output logic [IW-1:0]    o_idx,
    output logic             o_any
);

    // Scan upward from the pointer and keep the first hit.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        o_any = 1'b0;
        o_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            logic [IW-1:0] w_pos;
            w_pos = IW'((int'(i_ptr) + k) % N_REQ);
            if (!o_any && i_req[w_pos]) begin
                o_any = 1'b1;
                o_idx = w_pos;
            end
        end
    end

    // Expand the winning index into a one-hot grant.
    always_comb begin
        o_onehot = '0;
        if (o_any) o_onehot[o_idx] = 1'b1;
    end

endmodule

// File: rtl/spi_request_arbiter.sv
// Shares one byte-wide SPI master between N_REQ requesters: round-robin
// grant, one settle cycle for the new clock mode, launch, watchdog-guarded
// wait, and a one-cycle response back to the winner.
module spi_request_arbiter
    import spi_arb_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CW      = DEF_CW
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    spi_request_arbiter_if.slave  io_bus
);

    localparam int            IW       = idx_width(N_REQ);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [IW-1:0]    r_ptr;
    logic [N_REQ-1:0] r_gnt;
    logic [7:0]       r_m_data;
    logic             r_m_ckp;
    logic             r_m_cph;
    logic [CW-1:0]    r_cnt;
    logic [7:0]       r_rsp_data;
    logic             r_rsp_err;

    logic [N_REQ-1:0] w_pick_onehot;
    logic [IW-1:0]    w_pick_idx;
    logic             w_pick_any;
    logic [7:0]       w_sel_data;
    logic             w_expired;
    logic             w_start;
    logic             w_abort;
    logic [N_REQ-1:0] w_rsp_valid;

    spi_rr_picker #(.N_REQ(N_REQ)) u_picker (
        .i_req    (io_bus.req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    // Select the candidate winner's byte with a one-hot mux.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick_onehot[i]) w_sel_data = io_bus.req_data[8*i +: 8];
        end
    end

    assign w_expired = (r_cnt == CNT_LAST);

    // State register with synchronous reset.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic; M_DONE has priority over watchdog expiry.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_pick_any) w_next = SETUP;
            SETUP:   w_next = LAUNCH;
            LAUNCH:  w_next = WAIT;
            WAIT:    if (io_bus.m_done || w_expired) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Per-state pulse outputs.
    always_comb begin
        w_start     = 1'b0;
        w_abort     = 1'b0;
        w_rsp_valid = '0;
        case (r_state)
            LAUNCH:  w_start     = 1'b1;
            WAIT:    w_abort     = w_expired && !io_bus.m_done;
            RESP:    w_rsp_valid = r_gnt;
            default: ;
        endcase
    end

    // Grant/datapath registers, pointer and watchdog counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr      <= '0;
            r_gnt      <= '0;
            r_m_data   <= '0;
            r_m_ckp    <= 1'b0;
            r_m_cph    <= 1'b0;
            r_cnt      <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Inputs are captured only here; later changes cannot disturb the transfer.
                    if (w_pick_any) begin
                        r_gnt    <= w_pick_onehot;
                        r_m_data <= w_sel_data;
                        r_m_ckp  <= |(io_bus.req_ckp & w_pick_onehot);
                        r_m_cph  <= |(io_bus.req_cph & w_pick_onehot);
                        r_ptr    <= (w_pick_idx == IW'(N_REQ - 1)) ? '0 : w_pick_idx + 1'b1;
                    end
                end
                LAUNCH: r_cnt <= '0;
                WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (io_bus.m_done) begin
                        r_rsp_data <= io_bus.m_rx;
                        r_rsp_err  <= 1'b0;
                    end else if (w_expired) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                    end
                end
                RESP: begin
                    r_gnt     <= '0;
                    r_rsp_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign io_bus.gnt       = r_gnt;
    assign io_bus.rsp_valid = w_rsp_valid;
    assign io_bus.rsp_data  = r_rsp_data;
    assign io_bus.rsp_err   = r_rsp_err;
    assign io_bus.m_data    = r_m_data;
    assign io_bus.m_ckp     = r_m_ckp;
    assign io_bus.m_cph     = r_m_cph;
    assign io_bus.m_start   = w_start;
    assign io_bus.m_abort   = w_abort;

endmodule

// File: tb/tb_spi_request_arbiter.sv
// Self-checking bench for spi_request_arbiter: expected responses are queued
// when a transfer is granted and compared when RSP_VALID pulses.
module tb_spi_request_arbiter;

    typedef struct {
        int         idx;
        logic [7:0] data;
        logic       err;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   n_start;
    int   n_abort;
    int   exp_starts;
    exp_t sb[$];
    exp_t mon_e;

    spi_request_arbiter_if #(.N_REQ(4)) bus ();

    spi_request_arbiter #(.N_REQ(4), .TIMEOUT(64), .CW(7)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .io_bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Response monitor: samples after inputs have settled for the cycle.
    always begin
        @(negedge clk);
        #2;
        if (bus.m_start) n_start++;
        if (bus.m_abort) n_abort++;
        if (bus.rsp_valid != '0) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_rsp_valid", 32'(bus.rsp_valid), 32'(1) << mon_e.idx);
                check("sb_rsp_data", 32'(bus.rsp_data), 32'(mon_e.data));
                check("sb_rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic do_reset();
        reset = 1'b1;
        bus.req = '0;
        bus.m_done = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(bus.gnt), 0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_rsp_data", 32'(bus.rsp_data), 0);
        check("rst_m_data", 32'(bus.m_data), 0);
        check("rst_ctrl", 32'({bus.m_start, bus.m_abort, bus.rsp_err, bus.m_ckp, bus.m_cph}), 0);
        reset = 1'b0;
    endtask

    task automatic start_req(input logic [3:0] mask);
        @(negedge clk);
        bus.req = mask;
    endtask

    task automatic wait_grant(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.gnt == '0 && lat < 40);
    endtask

    // One complete transfer; M_DONE arrives done_after cycles after M_START.
    task automatic do_transfer(input int exp_w, input logic [7:0] exp_data,
                               input logic exp_ckp, input logic exp_cph,
                               input int exp_lat, input int done_after,
                               input logic [7:0] rx, input bit perturb);
        int lat;
        wait_grant(lat);
        check("grant_lat", lat, exp_lat);
        check("gnt", 32'(bus.gnt), 32'(1) << exp_w);
        check("m_data", 32'(bus.m_data), 32'(exp_data));
        check("m_mode", 32'({bus.m_ckp, bus.m_cph}), 32'({exp_ckp, exp_cph}));
        check("start_early", 32'(bus.m_start), 0);
        sb.push_back('{exp_w, rx, 1'b0});
        exp_starts++;
        @(negedge clk);
        check("start", 32'(bus.m_start), 1);
        for (int k = 1; k <= done_after; k++) begin
            @(negedge clk);
            if (perturb && k == 3) begin
                bus.req_data = bus.req_data | (32'hFF << (8 * exp_w));
                bus.req      = bus.req & ~(4'(1) << exp_w);
                bus.req_ckp  = bus.req_ckp ^ (4'(1) << exp_w);
            end
        end
        bus.m_done = 1'b1;
        bus.m_rx   = rx;
        #1;
        check("no_abort", 32'(bus.m_abort), 0);
        check("m_data_hold", 32'(bus.m_data), 32'(exp_data));
        check("m_ckp_hold", 32'(bus.m_ckp), 32'(exp_ckp));
        check("gnt_hold", 32'(bus.gnt), 32'(1) << exp_w);
        @(negedge clk);
        bus.m_done = 1'b0;
        check("rsp_valid", 32'(bus.rsp_valid), 32'(1) << exp_w);
    endtask

    initial begin
        logic [3:0] ckp_pat;
        logic [3:0] cph_pat;
        int         lat;
        int         abort_at;
        int         rsp_at;
        bit         seen;

        n_checks = 0; n_errors = 0; n_start = 0; n_abort = 0; exp_starts = 0;
        reset = 1'b1;
        bus.req = '0; bus.req_data = '0; bus.req_ckp = '0; bus.req_cph = '0;
        bus.m_done = 1'b0; bus.m_rx = '0;
        do_reset();

        // Single request: grant at t+1, start at t+2, done at t+10, response at t+11.
        bus.req_data = 32'h0000_00A5; bus.req_ckp = 4'b0001; bus.req_cph = 4'b0000;
        start_req(4'b0001);
        do_transfer(0, 8'hA5, 1'b1, 1'b0, 1, 8, 8'h3C, 1'b0);
        bus.req = '0;
        @(negedge clk);
        check("idle_gnt", 32'(bus.gnt), 0);
        check("idle_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rsp_data_hold", 32'(bus.rsp_data), 32'h3C);
        check("idle_rsp_err", 32'(bus.rsp_err), 0);

        // Reset from a non-zero datapath state, then fairness from pointer 0.
        do_reset();
        ckp_pat = 4'b1010; cph_pat = 4'b0110;
        bus.req_data = 32'h1312_1110; bus.req_ckp = ckp_pat; bus.req_cph = cph_pat;
        start_req(4'b1111);
        for (int k = 0; k < 5; k++) begin
            int w;
            w = k % 4;
            do_transfer(w, 8'(8'h10 + w), 1'(ckp_pat >> w), 1'(cph_pat >> w),
                        (k == 0) ? 1 : 2, 5, 8'(8'hC0 + k), 1'b0);
        end
        bus.req = '0;

        // Timeout: abort 64 cycles after M_START, error response one cycle later.
        start_req(4'b0100);
        wait_grant(lat);
        check("to_grant_lat", lat, 1);
        check("to_gnt", 32'(bus.gnt), 32'h4);
        sb.push_back('{2, 8'h00, 1'b1});
        exp_starts++;
        @(negedge clk);
        check("to_start", 32'(bus.m_start), 1);
        abort_at = 0; rsp_at = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            #1;
            if (bus.m_abort && abort_at == 0) abort_at = k;
            if (bus.rsp_valid != '0) begin
                rsp_at = k;
                break;
            end
        end
        check("abort_at", abort_at, 64);
        check("to_rsp_at", rsp_at, 65);
        check("to_rsp_valid", 32'(bus.rsp_valid), 32'h4);
        check("to_rsp_err", 32'(bus.rsp_err), 1);
        check("to_rsp_data", 32'(bus.rsp_data), 0);
        check("abort_one_cycle", 32'(bus.m_abort), 0);
        bus.req = '0;

        // Race: M_DONE on the expiry cycle wins, no abort.
        start_req(4'b0100);
        do_transfer(2, 8'h12, 1'b0, 1'b1, 1, 64, 8'h96, 1'b0);
        bus.req = '0;
        check("abort_count", n_abort, 1);

        // Robustness: inputs change and REQ drops mid-transfer.
        bus.req_data = (bus.req_data & 32'hFFFF_FF00) | 32'hA5;
        bus.req_ckp = 4'b1011; bus.req_cph = 4'b0110;
        start_req(4'b0001);
        do_transfer(0, 8'hA5, 1'b1, 1'b0, 1, 6, 8'h5A, 1'b1);
        bus.req = '0;

        // Stray M_DONE while idle must produce nothing.
        repeat (2) @(negedge clk);
        bus.m_done = 1'b1; bus.m_rx = 8'h77;
        @(negedge clk);
        bus.m_done = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.rsp_valid != '0 || bus.gnt != '0 || bus.m_start) seen = 1'b1;
        end
        check("stray_done", 32'(seen), 0);
        check("stray_rsp_data", 32'(bus.rsp_data), 32'h5A);

        // Reset on the third WAIT cycle.
        bus.req_data = (bus.req_data & 32'hFF00_FFFF) | 32'h00C3_0000;
        bus.req_ckp = 4'b0100; bus.req_cph = 4'b0100;
        start_req(4'b0100);
        wait_grant(lat);
        check("rw_gnt", 32'(bus.gnt), 32'h4);
        check("rw_ckp", 32'(bus.m_ckp), 1);
        exp_starts++;
        @(negedge clk);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bus.req = '0;
        @(negedge clk);
        check("rw_gnt_clr", 32'(bus.gnt), 0);
        check("rw_m_data", 32'(bus.m_data), 0);
        check("rw_rsp_data", 32'(bus.rsp_data), 0);
        check("rw_ctrl", 32'({bus.m_start, bus.m_abort, bus.m_ckp, bus.m_cph, bus.rsp_err}), 0);
        check("rw_rsp_valid", 32'(bus.rsp_valid), 0);
        reset = 1'b0;
        check("rw_no_abort", n_abort, 1);

        // Pointer back at 0: 1010 must pick requester 1, not 3.
        bus.req_data = (bus.req_data & 32'hFFFF_00FF) | 32'h0000_1100;
        bus.req_ckp = 4'b0000; bus.req_cph = 4'b0010;
        start_req(4'b1010);
        do_transfer(1, 8'h11, 1'b0, 1'b1, 1, 5, 8'hE7, 1'b0);
        bus.req = '0;

        repeat (3) @(negedge clk);
        check("start_count", n_start, exp_starts);
        check("abort_total", n_abort, 1);
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
